riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle RV32I main decoder. A registered Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Over the combinational decoder it adds: memory handshake with optional wait-timeout, funct3 legality checking, a sticky trap state, and a retired-instruction counter.
- Sits between the instruction register/flags and the multicycle datapath.

Parameters:
- MEM_WAIT_EN, 1, 1: FETCH/MEMREAD/MEMWRITE hold until mem_ready. 0: mem_ready ignored, each access takes one cycle.
- WAIT_TIMEOUT, 16, maximum wait cycles in any memory state before trap. 0 disables the timeout.
- TRAP_EN, 1, 1: illegal instruction or timeout enters TRAP. 0: illegal instruction returns to FETCH as a NOP, and timeout is disabled.
- CNT_W, 32, width of retired counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode from IR.
- funct3  in  3  instruction funct3 from IR.
- branch_taken  in  1  comparator result for current funct3.
- mem_ready  in  1  memory completes access this cycle.
- trap_clear  in  1  leave TRAP.
- mem_req  out  1  memory access request.
- MemWrite  out  1  store strobe.
- AdrSrc  out  1  0=PC, 1=Result.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  PC <= Result.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero.
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=4.
- ALUOp  out  2  00=add, 01=branch compare, 10=funct decode.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- BranchType  out  3  registered funct3 of branch.
- LoadType  out  3  registered funct3 of load/store.
- state  out  4  current state code.
- illegal  out  1  one-cycle pulse on illegal decode.
- trap  out  1  high while in TRAP.
- retire  out  1  one-cycle pulse on instruction completion.
- retired  out  CNT_W  retired count, wraps modulo 2^CNT_W.

Behaviour:
- Reset: state=FETCH(0), BranchType=LoadType=0, retired=0, wait counter=0.
- Reset mid-instruction aborts immediately. No MemWrite or RegWrite is issued during reset.
- Unlisted outputs are 0 in every state. ALUSrcA/ALUSrcB/ALUOp/ResultSrc are 0 unless listed.
- State codes: FETCH0, DECODE1, MEMADR2, MEMREAD3, MEMWB4, MEMWRITE5, EXECR6, EXECI7, ALUWB8, BRANCH9, JAL10, JALR11, LUI12, AUIPC13, TRAP14.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcB=10, ResultSrc=10.
  - IRWrite=PCWrite=1 only in the cycle the access completes (mem_ready=1, or always when MEM_WAIT_EN=0), then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut<=OldPC+imm). Registers funct3 into BranchType (B-type) or LoadType (load/store).
  - Next state by op: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BRANCH; 1101111→JAL; 1100111→JALR; 0110111→LUI; 0010111→AUIPC.
- Illegal decode: unknown op; branch funct3 010/011; load funct3 011/110/111; store funct3>010; jalr funct3≠000.
  - Pulses illegal, then TRAP if TRAP_EN, else FETCH with retire=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next is MEMREAD for a load, MEMWRITE for a store. The op is held stable by the IR.
- MEMREAD: mem_req=1, AdrSrc=1. On completion go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, then FETCH.
- MEMWRITE: mem_req=MemWrite=1, AdrSrc=1. On completion retire=1 and go to FETCH. MemWrite stays high for the whole wait.
- EXECR: ALUSrcA=10, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: RegWrite=1, retire=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUOp=01, PCWrite=branch_taken, retire=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, PCWrite=1 (PC<=ALUOut), then ALUWB (rd<=OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01 (ALUOut<=rs1+imm), then JAL.
- LUI: ALUSrcA=11, ALUSrcB=01, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, then ALUWB.
- Wait counter:
  - Clears on entry to each memory state and increments each cycle without completion.
  - If TRAP_EN and WAIT_TIMEOUT>0 and the count reaches WAIT_TIMEOUT, go to TRAP. mem_req drops. No IRWrite/PCWrite/MemWrite follow.
  - Completion in the same cycle the count reaches the limit wins: no trap.
- TRAP: trap=1, all strobes 0. trap_clear=1 moves to FETCH next cycle, and retired is unchanged.
- retired increments on each retire pulse and wraps to 0 after all ones.

Test Plan:
- Reset with state=MEMWRITE held waiting (rst_n low) → state=0, MemWrite=0, retired=0 asynchronously, before any clk edge.
- add (op 0110011), mem_ready=1 → states 0,1,6,8,0. RegWrite only in ALUWB. retire once. retired=1.
- lw (op 0000011, funct3 010), MEM_WAIT_EN=1, mem_ready low 3 cycles in MEMREAD → MEMREAD held 4 cycles. LoadType=010. RegWrite with ResultSrc=01. Total 8 cycles.
- beq with branch_taken=0, then with branch_taken=1 → PCWrite=0 / 1 in BRANCH. BranchType=000. Both retire.
- jalr → states 1,11,10,8. PCWrite in JAL. RegWrite in ALUWB.
- op=1111111 → illegal pulse, TRAP, trap=1, retired unchanged. trap_clear → FETCH.
- FETCH with mem_ready never asserted, WAIT_TIMEOUT=16 → TRAP after 16 waiting cycles. IRWrite never asserted.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
// riscv_multicycle_ctrl : multicycle RV32I control FSM with memory handshake,
//                         wait timeout, sticky trap and retired counter.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_multicycle_ctrl #(
  parameter int MEM_WAIT_EN  = 1,
  parameter int WAIT_TIMEOUT = 16,
  parameter int TRAP_EN      = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             trap_clear,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       BranchType,
  output logic [2:0]       LoadType,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] c_FETCH    = 4'd0;
  localparam logic [3:0] c_DECODE   = 4'd1;
  localparam logic [3:0] c_MEMADR   = 4'd2;
  localparam logic [3:0] c_MEMREAD  = 4'd3;
  localparam logic [3:0] c_MEMWB    = 4'd4;
  localparam logic [3:0] c_MEMWRITE = 4'd5;
  localparam logic [3:0] c_EXECR    = 4'd6;
  localparam logic [3:0] c_EXECI    = 4'd7;
  localparam logic [3:0] c_ALUWB    = 4'd8;
  localparam logic [3:0] c_BRANCH   = 4'd9;
  localparam logic [3:0] c_JAL      = 4'd10;
  localparam logic [3:0] c_JALR     = 4'd11;
  localparam logic [3:0] c_LUI      = 4'd12;
  localparam logic [3:0] c_AUIPC    = 4'd13;
  localparam logic [3:0] c_TRAP     = 4'd14;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  localparam int             c_WCW     = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [c_WCW-1:0] c_TIMEOUT = c_WCW'(WAIT_TIMEOUT);
  localparam logic           c_TO_EN   = (TRAP_EN != 0) && (WAIT_TIMEOUT != 0);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [c_WCW-1:0] r_wait_cnt;
  logic [c_WCW-1:0] w_cnt_inc;
  logic [2:0]       r_branch_type;
  logic [2:0]       r_load_type;
  logic [CNT_W-1:0] r_retired;
  logic             w_done;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_ill;
  logic [3:0]       w_dec_next;

  assign w_done      = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign w_mem_state = (r_state == c_FETCH) || (r_state == c_MEMREAD) || (r_state == c_MEMWRITE);
  assign w_cnt_inc   = r_wait_cnt + c_WCW'(1);
  // The cycle whose increment would hit the limit traps unless the access completes in it.
  assign w_timeout   = c_TO_EN && w_mem_state && !w_done && (w_cnt_inc == c_TIMEOUT);

  always_comb begin
    w_ill      = 1'b0;
    w_dec_next = c_FETCH;
    case (op)
      c_OP_LOAD: begin
        w_dec_next = c_MEMADR;
        w_ill      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      c_OP_STORE: begin
        w_dec_next = c_MEMADR;
        w_ill      = (funct3 > 3'b010);
      end
      c_OP_R:     w_dec_next = c_EXECR;
      c_OP_I:     w_dec_next = c_EXECI;
      c_OP_BR: begin
        w_dec_next = c_BRANCH;
        w_ill      = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      c_OP_JAL:   w_dec_next = c_JAL;
      c_OP_JALR: begin
        w_dec_next = c_JALR;
        w_ill      = (funct3 != 3'b000);
      end
      c_OP_LUI:   w_dec_next = c_LUI;
      c_OP_AUIPC: w_dec_next = c_AUIPC;
      default:    w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_FETCH:    w_next = w_done ? c_DECODE : (w_timeout ? c_TRAP : c_FETCH);
      c_DECODE:   w_next = w_ill ? ((TRAP_EN != 0) ? c_TRAP : c_FETCH) : w_dec_next;
      c_MEMADR:   w_next = (op == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
      c_MEMREAD:  w_next = w_done ? c_MEMWB : (w_timeout ? c_TRAP : c_MEMREAD);
      c_MEMWB:    w_next = c_FETCH;
      c_MEMWRITE: w_next = w_done ? c_FETCH : (w_timeout ? c_TRAP : c_MEMWRITE);
      c_EXECR:    w_next = c_ALUWB;
      c_EXECI:    w_next = c_ALUWB;
      c_ALUWB:    w_next = c_FETCH;
      c_BRANCH:   w_next = c_FETCH;
      c_JAL:      w_next = c_ALUWB;
      c_JALR:     w_next = c_JAL;
      c_LUI:      w_next = c_ALUWB;
      c_AUIPC:    w_next = c_ALUWB;
      c_TRAP:     w_next = trap_clear ? c_FETCH : c_TRAP;
      default:    w_next = c_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_FETCH;
      r_wait_cnt    <= '0;
      r_branch_type <= 3'b000;
      r_load_type   <= 3'b000;
      r_retired     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next) begin
        r_wait_cnt <= '0;
      end else if (w_mem_state && !w_done && (r_wait_cnt != '1)) begin
        r_wait_cnt <= w_cnt_inc;
      end
      if (r_state == c_DECODE) begin
        if (op == c_OP_BR) begin
          r_branch_type <= funct3;
        end
        if ((op == c_OP_LOAD) || (op == c_OP_STORE)) begin
          r_load_type <= funct3;
        end
      end
      if (retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    illegal   = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;
    case (r_state)
      c_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_done;
        PCWrite   = w_done;
      end
      c_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        illegal = w_ill;
        retire  = w_ill && (TRAP_EN == 0);
      end
      c_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      c_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      c_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        retire   = w_done;
      end
      c_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      c_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      c_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      c_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = branch_taken;
        retire  = 1'b1;
      end
      c_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      c_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      c_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      c_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state      = r_state;
  assign BranchType = r_branch_type;
  assign LoadType   = r_load_type;
  assign retired    = r_retired;

endmodule

`default_nettype wire
